// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: state encoding, default dividers
// and a counter-width helper.
package tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } state_e;

    localparam int FAST_DIV_DEF = 50000;
    localparam int SLOW_DIV_DEF = 1000;
    localparam int CNT_W_DEF    = 16;

    // Width of a modulo-n counter; the dividers are always >= 2.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_sched_mod_counter.sv
// Modulo-N counter with enable, synchronous clear and a registered wrap pulse.
// at_max_o lets the parent act on the wrap in the same edge it happens.
module mod_counter
    import tick_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic at_max_o,
    output logic wrap_o
);

    localparam int W = cnt_width(N);
    localparam logic [W-1:0] MAX = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;

    assign at_max_o = (cnt_q == MAX);
    assign wrap_o   = wrap_q;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (at_max_o) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

endmodule

// File: rtl/tick_sched.sv
// Run/pause/clear controller over a prescaler and slow-tick counter chain,
// driving a loadable countdown that flags expiry with a one-cycle done pulse.
module tick_sched
    import tick_pkg::*;
#(
    parameter int FAST_DIV = FAST_DIV_DEF,
    parameter int SLOW_DIV = SLOW_DIV_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             clear_i,
    input  logic             load_en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             fast_tick_o,
    output logic             slow_tick_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic [1:0]       state_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;

    logic load_acc;
    logic start_idle;
    logic run_en;
    logic cnt_clr;
    logic fast_max, slow_max;
    logic fast_wrap, slow_wrap;

    // load_en is dropped while running; start from IDLE needs a non-zero count.
    assign load_acc   = load_en_i && !clear_i && (state_q != ST_RUN);
    assign start_idle = start_i && !clear_i && !load_en_i &&
                        (state_q == ST_IDLE) && (remaining_q != '0);
    assign run_en     = (state_q == ST_RUN) && !clear_i && !pause_i;
    assign cnt_clr    = clear_i || load_acc || start_idle;

    assign fast_wrap  = run_en && fast_max;
    assign slow_wrap  = fast_wrap && slow_max;

    mod_counter #(.N(FAST_DIV)) u_prescaler (
        .clk_i    (clk_i),
        .rst_i    (reset_i),
        .en_i     (run_en),
        .clr_i    (cnt_clr),
        .at_max_o (fast_max),
        .wrap_o   (fast_tick_o)
    );

    mod_counter #(.N(SLOW_DIV)) u_slow_cnt (
        .clk_i    (clk_i),
        .rst_i    (reset_i),
        .en_i     (fast_wrap),
        .clr_i    (cnt_clr),
        .at_max_o (slow_max),
        .wrap_o   (slow_tick_o)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        if (clear_i) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
        end else if (load_acc) begin
            state_d     = ST_IDLE;
            remaining_d = load_val_i;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_idle) state_d = ST_RUN;
                end
                ST_PAUSED: begin
                    if (start_i) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (pause_i) begin
                        state_d = ST_PAUSED;
                    end else if (slow_wrap && (remaining_q != '0)) begin
                        // Both counters wrap to zero on this same edge.
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    assign state_o     = state_q;
    assign remaining_o = remaining_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched with FAST_DIV=4, SLOW_DIV=3, CNT_W=8.
module tb_tick_sched;

    localparam int F = 4;
    localparam int S = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0, pause = 1'b0, clear = 1'b0, load_en = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         fast_tick, slow_tick, done;
    logic [W-1:0] remaining;
    logic [1:0]   state;
    logic [12:0]  dut_vec;
    logic [12:0]  want;

    int vectors = 0;
    int errors  = 0;

    // Reference model: state code, countdown and run edges since the last slow period.
    int m_st, m_rem, m_el;
    bit m_fast, m_slow, m_done;

    tick_sched #(.FAST_DIV(F), .SLOW_DIV(S), .CNT_W(W)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .pause_i     (pause),
        .clear_i     (clear),
        .load_en_i   (load_en),
        .load_val_i  (load_val),
        .fast_tick_o (fast_tick),
        .slow_tick_o (slow_tick),
        .remaining_o (remaining),
        .state_o     (state),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    assign dut_vec = {state, remaining, fast_tick, slow_tick, done};

    function automatic logic [12:0] pack(input int st, input int rem, input bit f, input bit s, input bit d);
        logic [1:0]   st2;
        logic [W-1:0] r8;
        st2 = st[1:0];
        r8  = rem[W-1:0];
        return {st2, r8, f, s, d};
    endfunction

    function automatic logic [12:0] exp_vec();
        return pack(m_st, m_rem, m_fast, m_slow, m_done);
    endfunction

    task automatic model_reset();
        m_st = 0; m_rem = 0; m_el = 0;
        m_fast = 0; m_slow = 0; m_done = 0;
    endtask

    task automatic model_step();
        m_fast = 0; m_slow = 0; m_done = 0;
        if (clear) begin
            m_st = 0; m_rem = 0; m_el = 0;
        end else if (load_en && m_st != 1) begin
            m_st = 0; m_rem = int'(load_val); m_el = 0;
        end else if (m_st == 1) begin
            if (pause) begin
                m_st = 2;
            end else begin
                m_el++;
                if (m_el % F == 0) m_fast = 1;
                if (m_el % (F * S) == 0) begin
                    m_slow = 1;
                    m_el = 0;
                    if (m_rem > 0) m_rem--;
                    if (m_rem == 0) begin
                        m_st = 3;
                        m_done = 1;
                    end
                end
            end
        end else if (start && m_st == 0 && m_rem != 0) begin
            m_st = 1; m_el = 0;
        end else if (start && m_st == 2) begin
            m_st = 1;
        end
    endtask

    // One clock edge: inputs are stable, model follows, outputs settle by +1.
    task automatic edge_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cmd_clear();
        clear = 1'b1; edge_step(); clear = 1'b0;
    endtask

    task automatic cmd_load(input int v);
        load_en = 1'b1; load_val = W'(v); edge_step(); load_en = 1'b0;
    endtask

    task automatic cmd_start();
        start = 1'b1; edge_step(); start = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (dut_vec !== 13'h0) begin
            errors++;
            $display("FAIL reset_init: got %h want %h", dut_vec, 13'h0);
        end
        reset = 1'b0;
        cmd_load(2);
        cmd_start();
        repeat (5) edge_step();
        vectors++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL reset_prerun: state got %b want 01", state);
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (dut_vec !== 13'h0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", dut_vec, 13'h0);
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int d_st, d_rem;
        bit d_f, d_s, d_d;
        cmd_clear();
        cmd_load(2);
        cmd_start();
        for (int n = 1; n <= 26; n++) begin
            edge_step();
            d_f   = (n % 4 == 0) && (n <= 24);
            d_s   = (n == 12) || (n == 24);
            d_d   = (n == 24);
            d_rem = (n < 12) ? 2 : ((n < 24) ? 1 : 0);
            d_st  = (n < 24) ? 1 : 3;
            want  = pack(d_st, d_rem, d_f, d_s, d_d);
            vectors++;
            if (dut_vec !== want) begin
                errors++;
                $display("FAIL basic E%0d: got %h want %h", n, dut_vec, want);
            end
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL basic_model E%0d: got %h want %h", n, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_pause_resume();
        int d_st, d_rem;
        bit d_f, d_s;
        cmd_clear();
        cmd_load(2);
        cmd_start();
        for (int n = 1; n <= 20; n++) begin
            pause = (n == 6);
            start = (n == 10);
            edge_step();
            pause = 1'b0;
            start = 1'b0;
            d_f   = (n == 4) || (n == 13) || (n == 17);
            d_s   = (n == 17);
            d_rem = (n < 17) ? 2 : 1;
            d_st  = (n < 6) ? 1 : ((n < 10) ? 2 : 1);
            want  = pack(d_st, d_rem, d_f, d_s, 1'b0);
            vectors++;
            if (dut_vec !== want) begin
                errors++;
                $display("FAIL pause E%0d: got %h want %h", n, dut_vec, want);
            end
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL pause_model E%0d: got %h want %h", n, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_priority();
        cmd_clear();
        cmd_load(2);
        cmd_start();
        repeat (2) edge_step();
        pause = 1'b1; edge_step(); pause = 1'b0;
        vectors++;
        if (dut_vec !== pack(2, 2, 0, 0, 0)) begin
            errors++;
            $display("FAIL prio_pause: got %h want %h", dut_vec, pack(2, 2, 0, 0, 0));
        end
        clear = 1'b1; load_en = 1'b1; load_val = 8'd7;
        edge_step();
        clear = 1'b0; load_en = 1'b0;
        vectors++;
        if (dut_vec !== pack(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL prio_clear_load: got %h want %h", dut_vec, pack(0, 0, 0, 0, 0));
        end
        cmd_load(3);
        cmd_start();
        edge_step();
        cmd_load(9);
        vectors++;
        if (dut_vec !== pack(1, 3, 0, 0, 0)) begin
            errors++;
            $display("FAIL prio_load_in_run: got %h want %h", dut_vec, pack(1, 3, 0, 0, 0));
        end
        pause = 1'b1; start = 1'b1;
        edge_step();
        pause = 1'b0; start = 1'b0;
        vectors++;
        if (dut_vec !== pack(2, 3, 0, 0, 0)) begin
            errors++;
            $display("FAIL prio_pause_start: got %h want %h", dut_vec, pack(2, 3, 0, 0, 0));
        end
        vectors++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL prio_model: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_guard();
        cmd_clear();
        start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            edge_step();
            vectors++;
            if (dut_vec !== 13'h0) begin
                errors++;
                $display("FAIL guard_idle_zero E%0d: got %h want %h", n, dut_vec, 13'h0);
            end
        end
        start = 1'b0;
        cmd_load(1);
        cmd_start();
        for (int n = 1; n <= 14; n++) begin
            edge_step();
            want = pack((n < 12) ? 1 : 3, (n < 12) ? 1 : 0, (n % 4 == 0) && (n <= 12), n == 12, n == 12);
            vectors++;
            if (dut_vec !== want) begin
                errors++;
                $display("FAIL guard_load1 E%0d: got %h want %h", n, dut_vec, want);
            end
        end
        start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            edge_step();
            vectors++;
            if (dut_vec !== pack(3, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL guard_start_expired E%0d: got %h want %h", n, dut_vec, pack(3, 0, 0, 0, 0));
            end
        end
        start = 1'b0;
        vectors++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL guard_model: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_long_run();
        int  n_fast = 0, n_slow = 0, prev_rem = 255, bad = 0;
        bit  seen_done = 0;
        cmd_clear();
        cmd_load(255);
        cmd_start();
        for (int n = 1; n <= 4000 && !seen_done; n++) begin
            edge_step();
            n_fast += int'(fast_tick);
            n_slow += int'(slow_tick);
            if (int'(remaining) > prev_rem || dut_vec !== exp_vec()) bad++;
            prev_rem  = int'(remaining);
            seen_done = (done === 1'b1);
        end
        vectors++;
        if (!seen_done) begin
            errors++;
            $display("FAIL long_done_timeout: done got 0 want 1 within 4000 edges");
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL long_trace: %0d bad cycles, want 0", bad);
        end
        vectors++;
        if (n_slow != 255) begin
            errors++;
            $display("FAIL long_slow_count: got %0d want 255", n_slow);
        end
        vectors++;
        if (n_fast != 765) begin
            errors++;
            $display("FAIL long_fast_count: got %0d want 765", n_fast);
        end
    endtask

    task automatic test_random();
        int r;
        cmd_clear();
        for (int n = 0; n < 1500; n++) begin
            r        = $urandom_range(0, 99);
            clear    = (r < 2);
            load_en  = (r >= 2 && r < 6);
            load_val = W'($urandom_range(0, 3));
            pause    = ($urandom_range(0, 99) < 5);
            start    = ($urandom_range(0, 99) < 12);
            edge_step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d: got %h want %h", n, dut_vec, exp_vec());
            end
        end
        clear = 1'b0; load_en = 1'b0; pause = 1'b0; start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause_resume();
        test_priority();
        test_guard();
        test_long_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
